carregador_prog: RTL and testbench
==================================

Name: carregador_prog

Overview:
- Boot-time program loader that sits directly upstream of the single-cycle core's instruction memory.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes the words into instruction memory, then checks a trailing 8-bit checksum.
- Holds the core stopped until the load completes correctly, then releases it via core_run.

Parameters:
- N_PALAVRAS, 16, instruction-memory capacity in words (matches the 6-bit byte-addressed fetch space).
- LARG_END, 6, width of the byte address driven to instruction memory.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- inicio  input  1  single-cycle start pulse; samples len.
- len  input  5  number of words to load; legal range 1..N_PALAVRAS.
- byte_in  input  8  stream data.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory write enable.
- mem_ender  output  LARG_END  byte address of the word written (word-aligned).
- mem_dado  output  32  word written.
- ocupado  output  1  load in progress.
- core_run  output  1  core released; a level signal.
- erro  output  1  load failed (bad len or bad checksum); a level signal.
- palavras  output  5  count of words written so far.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to OCIOSO.
  - All outputs = 0.
  - Internal byte counter, word index, checksum accumulator and assembly register = 0.
  - Asserting rst mid-load aborts the load immediately; memory contents already written are left as-is.
- A handshake transfer occurs on a rising edge where byte_valid && byte_ready.
  - byte_valid held without ready: no transfer and no state change.
  - The source may drop byte_valid at any time.
- OCIOSO:
  - byte_ready=0, ocupado=0.
  - On inicio: if len==0 or len>N_PALAVRAS, go to ERRO; otherwise latch len, clear counters, go to RECEBE.
- RECEBE:
  - byte_ready=1, ocupado=1.
  - Each transfer places byte k (k=0..3) into assembly bits [8k+7:8k] and adds the byte into the 8-bit checksum (mod 256).
  - After the 4th byte, go to ESCREVE; byte_ready drops on the next cycle.
- ESCREVE (exactly 1 cycle):
  - mem_we=1, mem_ender = word_index*4, mem_dado = assembled word, byte_ready=0.
  - palavras increments at the end of the cycle; word_index increments.
  - If the new count == latched len, go to CHECA; otherwise go to RECEBE.
  - Latency from the 4th byte's transfer edge to the mem_we cycle is 1 clock.
- CHECA:
  - byte_ready=1, ocupado=1.
  - One transfer of the check byte.
  - If (accumulator + check byte) mod 256 == 0, go to FIM; otherwise go to ERRO.
- FIM:
  - core_run=1, ocupado=0, byte_ready=0.
  - Stays here until inicio or rst.
- ERRO:
  - erro=1, core_run=0, ocupado=0, byte_ready=0.
  - Stays here until inicio or rst.
- inicio in FIM or ERRO:
  - Clears core_run, erro and palavras in the same edge.
  - Re-evaluates len exactly as in OCIOSO.
- inicio in RECEBE, ESCREVE or CHECA is ignored; no restart mid-load.
- Width rules:
  - mem_ender uses only word_index[3:0] shifted left by 2; bits [1:0] are always 0.
  - len==N_PALAVRAS fills the whole memory without wrap.
- mem_dado and mem_ender are registered and hold their last value outside ESCREVE; only mem_we qualifies them.
- core_run is never 1 while ocupado is 1 or erro is 1.

Decomposition:
- Shared package holds:
  - FSM state encoding: OCIOSO, RECEBE, ESCREVE, CHECA, FIM, ERRO.
  - Constants N_PALAVRAS_MAX=16 and BYTES_POR_PALAVRA=4.
- One natural sub-module, montador_palavra:
  - Contains the byte counter, little-endian shift/assembly register and checksum accumulator.
  - Inputs: clr, byte strobe, byte.
  - Outputs: palavra, cheia (4th byte accepted), soma.
- The FSM and address/count logic stay in the top module.

Test Plan:
1. Reset then inicio with len=1; bytes 0x13,0x05,0x50,0x00; check byte 0x98 -> one mem_we cycle with mem_ender=0, mem_dado=0x00500513; then core_run=1, erro=0, palavras=1.
2. len=2; words 0x00100093 and 0x00208133 sent back-to-back with byte_valid held high, followed by the correct check byte -> two mem_we pulses at mem_ender=0 and mem_ender=4; byte_ready=0 in each ESCREVE cycle; core_run=1.
3. len=1, same data as scenario 1 but check byte 0x99 -> erro=1, core_run=0, one word written; then inicio with len=1 and the correct stream -> erro clears, core_run=1.
4. inicio with len=0, then separately with len=17 -> ERRO on the next cycle; no mem_we ever; byte_ready never asserts.
5. len=16 with byte_valid toggled pseudo-randomly -> 16 writes to addresses 0,4,...,60 with correct words; palavras=16; core_run only after the valid check byte.
6. rst asserted after the 2nd byte of the 3rd word, plus inicio asserted mid-RECEBE in a separate run -> rst makes all outputs 0 asynchronously; the mid-load inicio is ignored and the load completes normally.

Source files
------------

// File: rtl/carregador_prog_pkg.sv
// Shared definitions for the boot-time program loader.
// Holds the FSM state encoding and the word/byte geometry constants.
package carregador_prog_pkg;

    typedef enum logic [2:0] {
        OCIOSO,
        RECEBE,
        ESCREVE,
        CHECA,
        FIM,
        ERRO
    } estado_t;

    localparam int N_PALAVRAS_MAX    = 16;
    localparam int BYTES_POR_PALAVRA = 4;

endpackage

// File: rtl/carregador_prog_montador_palavra.sv
// Assembles four stream bytes into a little-endian word and keeps a running
// mod-256 sum of every accepted byte.
module montador_palavra
    import carregador_prog_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        strobe_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] palavra_o,
    output logic        cheia_o,
    output logic [7:0]  soma_o
);

    logic [1:0]  cnt_q;
    logic [31:0] asm_q;
    logic [31:0] asm_d;
    logic [7:0]  soma_q;

    // asm_d already contains the incoming byte, so the word is complete on the
    // same edge that accepts its last byte.
    always_comb begin
        asm_d = asm_q;
        case (cnt_q)
            2'd0:    asm_d[7:0]   = byte_i;
            2'd1:    asm_d[15:8]  = byte_i;
            2'd2:    asm_d[23:16] = byte_i;
            default: asm_d[31:24] = byte_i;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            asm_q  <= 32'd0;
            soma_q <= 8'd0;
        end else if (clr_i) begin
            cnt_q  <= 2'd0;
            asm_q  <= 32'd0;
            soma_q <= 8'd0;
        end else if (strobe_i) begin
            cnt_q  <= cnt_q + 2'd1;
            asm_q  <= asm_d;
            soma_q <= soma_q + byte_i;
        end
    end

    assign palavra_o = asm_d;
    assign cheia_o   = strobe_i && (cnt_q == 2'(BYTES_POR_PALAVRA - 1));
    assign soma_o    = soma_q;

endmodule

// File: rtl/carregador_prog.sv
// Boot-time program loader: receives a byte stream, writes words into
// instruction memory, verifies a trailing checksum and releases the core.
module carregador_prog
    import carregador_prog_pkg::*;
#(
    parameter int N_PALAVRAS = N_PALAVRAS_MAX,
    parameter int LARG_END   = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inicio,
    input  logic [4:0]          len,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic                byte_ready,
    output logic                mem_we,
    output logic [LARG_END-1:0] mem_ender,
    output logic [31:0]         mem_dado,
    output logic                ocupado,
    output logic                core_run,
    output logic                erro,
    output logic [4:0]          palavras
);

    estado_t             estado_q;
    logic [4:0]          len_q;
    logic [3:0]          idx_q;
    logic [4:0]          palavras_q;
    logic [4:0]          palavras_d;
    logic                byte_ready_q;
    logic                mem_we_q;
    logic [LARG_END-1:0] mem_ender_q;
    logic [31:0]         mem_dado_q;
    logic                ocupado_q;
    logic                core_run_q;
    logic                erro_q;

    logic        xfer;
    logic        parado;
    logic        aceita_inicio;
    logic        len_ok;
    logic        asm_clr;
    logic        asm_strobe;
    logic [31:0] asm_palavra;
    logic        asm_cheia;
    logic [7:0]  asm_soma;
    logic [7:0]  soma_final;

    assign xfer          = byte_valid && byte_ready_q;
    assign parado        = (estado_q == OCIOSO) || (estado_q == FIM) || (estado_q == ERRO);
    assign aceita_inicio = parado && inicio;
    assign len_ok        = (len != 5'd0) && (len <= 5'(N_PALAVRAS));
    assign asm_clr       = aceita_inicio;
    assign asm_strobe    = xfer && (estado_q == RECEBE);
    assign palavras_d    = palavras_q + 5'd1;
    assign soma_final    = asm_soma + byte_in;

    montador_palavra u_montador (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (asm_clr),
        .strobe_i (asm_strobe),
        .byte_i   (byte_in),
        .palavra_o(asm_palavra),
        .cheia_o  (asm_cheia),
        .soma_o   (asm_soma)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q     <= OCIOSO;
            len_q        <= 5'd0;
            idx_q        <= 4'd0;
            palavras_q   <= 5'd0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_ender_q  <= '0;
            mem_dado_q   <= 32'd0;
            ocupado_q    <= 1'b0;
            core_run_q   <= 1'b0;
            erro_q       <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (estado_q)
                OCIOSO, FIM, ERRO: begin
                    if (inicio) begin
                        core_run_q <= 1'b0;
                        erro_q     <= 1'b0;
                        palavras_q <= 5'd0;
                        idx_q      <= 4'd0;
                        if (len_ok) begin
                            len_q        <= len;
                            estado_q     <= RECEBE;
                            byte_ready_q <= 1'b1;
                            ocupado_q    <= 1'b1;
                        end else begin
                            estado_q <= ERRO;
                            erro_q   <= 1'b1;
                        end
                    end
                end
                RECEBE: begin
                    if (asm_cheia) begin
                        estado_q     <= ESCREVE;
                        byte_ready_q <= 1'b0;
                        mem_we_q     <= 1'b1;
                        mem_ender_q  <= LARG_END'({idx_q, 2'b00});
                        mem_dado_q   <= asm_palavra;
                    end
                end
                ESCREVE: begin
                    palavras_q   <= palavras_d;
                    idx_q        <= idx_q + 4'd1;
                    byte_ready_q <= 1'b1;
                    estado_q     <= (palavras_d == len_q) ? CHECA : RECEBE;
                end
                CHECA: begin
                    if (xfer) begin
                        byte_ready_q <= 1'b0;
                        ocupado_q    <= 1'b0;
                        if (soma_final == 8'd0) begin
                            estado_q   <= FIM;
                            core_run_q <= 1'b1;
                        end else begin
                            estado_q <= ERRO;
                            erro_q   <= 1'b1;
                        end
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign byte_ready = byte_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_ender  = mem_ender_q;
    assign mem_dado   = mem_dado_q;
    assign ocupado    = ocupado_q;
    assign core_run   = core_run_q;
    assign erro       = erro_q;
    assign palavras   = palavras_q;

endmodule

// File: tb/tb_carregador_prog.sv
// Directed bench for carregador_prog with a write scoreboard.
module tb_carregador_prog;

    logic        clk = 1'b0;
    logic        rst;
    logic        inicio;
    logic [4:0]  len;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [5:0]  mem_ender;
    logic [31:0] mem_dado;
    logic        ocupado;
    logic        core_run;
    logic        erro;
    logic [4:0]  palavras;

    int          errors = 0;
    int          checks = 0;
    int          n_we   = 0;
    int          we_base;
    bit          ready_seen = 1'b0;
    logic [37:0] sb[$];
    logic [37:0] sb_e;
    logic [7:0]  tb_sum;
    int          exp_idx;

    carregador_prog dut (
        .clk       (clk),
        .rst       (rst),
        .inicio    (inicio),
        .len       (len),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .mem_we    (mem_we),
        .mem_ender (mem_ender),
        .mem_dado  (mem_dado),
        .ocupado   (ocupado),
        .core_run  (core_run),
        .erro      (erro),
        .palavras  (palavras)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (byte_ready === 1'b1) ready_seen = 1'b1;
        if (rst === 1'b0) check("run_exclusive", {63'd0, core_run & (ocupado | erro)}, 64'd0);
        if (mem_we === 1'b1) begin
            n_we++;
            check("ready_in_escreve", {63'd0, byte_ready}, 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_we", 64'd1, 64'd0);
            end else begin
                sb_e = sb.pop_front();
                check("mem_ender", {58'd0, mem_ender}, {58'd0, sb_e[37:32]});
                check("mem_dado", {32'd0, mem_dado}, {32'd0, sb_e[31:0]});
            end
        end
    end

    task automatic start(input logic [4:0] l);
        inicio = 1'b1;
        len    = l;
        tb_sum = 8'd0;
        exp_idx = 0;
        @(negedge clk);
        inicio = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int n;
        if (rnd) begin
            byte_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        byte_in    = b;
        byte_valid = 1'b1;
        n = 0;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 64'd0, 64'd1);
        else @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd, input bit mid);
        logic [7:0] b;
        sb.push_back({6'(exp_idx * 4), w});
        exp_idx++;
        for (int k = 0; k < 4; k++) begin
            b = w[8*k +: 8];
            tb_sum = tb_sum + b;
            send_byte(b, rnd);
            if (mid && k == 1) begin
                byte_valid = 1'b0;
                inicio = 1'b1;
                len    = 5'd0;
                @(negedge clk);
                inicio = 1'b0;
                check("mid_inicio_ocupado", {63'd0, ocupado}, 64'd1);
                check("mid_inicio_erro", {63'd0, erro}, 64'd0);
            end
        end
    endtask

    task automatic send_check(input bit ok, input bit rnd);
        logic [7:0] b;
        b = 8'd0 - tb_sum;
        if (!ok) b = b + 8'd1;
        send_byte(b, rnd);
        byte_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(core_run === 1'b1 || erro === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        rst = 1'b1; inicio = 1'b0; len = 5'd0; byte_in = 8'd0; byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {16'd0, byte_ready, mem_we, mem_ender, mem_dado, ocupado, core_run, erro, palavras}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single word, fixed check byte
        start(5'd1);
        check("t1_ready", {63'd0, byte_ready}, 64'd1);
        sb.push_back({6'd0, 32'h00500513});
        send_byte(8'h13, 0); send_byte(8'h05, 0); send_byte(8'h50, 0); send_byte(8'h00, 0);
        send_byte(8'h98, 0);
        byte_valid = 1'b0;
        wait_done();
        check("t1_core_run", {63'd0, core_run}, 64'd1);
        check("t1_erro", {63'd0, erro}, 64'd0);
        check("t1_palavras", {59'd0, palavras}, 64'd1);
        check("t1_sb_empty", sb.size(), 64'd0);

        // 2: two words back to back
        we_base = n_we;
        start(5'd2);
        check("t2_run_cleared", {63'd0, core_run}, 64'd0);
        send_word(32'h00100093, 0, 0);
        send_word(32'h00208133, 0, 0);
        send_check(1, 0);
        wait_done();
        check("t2_core_run", {63'd0, core_run}, 64'd1);
        check("t2_writes", n_we - we_base, 64'd2);
        check("t2_sb_empty", sb.size(), 64'd0);

        // 3: bad checksum then recovery
        start(5'd1);
        send_word(32'h00500513, 0, 0);
        send_check(0, 0);
        wait_done();
        check("t3_erro", {63'd0, erro}, 64'd1);
        check("t3_core_run", {63'd0, core_run}, 64'd0);
        check("t3_palavras", {59'd0, palavras}, 64'd1);
        start(5'd1);
        check("t3_erro_cleared", {63'd0, erro}, 64'd0);
        check("t3_palavras_cleared", {59'd0, palavras}, 64'd0);
        send_word(32'h00500513, 0, 0);
        send_check(1, 0);
        wait_done();
        check("t3_recover_run", {63'd0, core_run}, 64'd1);
        check("t3_recover_erro", {63'd0, erro}, 64'd0);

        // 4: illegal lengths
        ready_seen = 1'b0;
        we_base = n_we;
        start(5'd0);
        check("t4_len0_erro", {63'd0, erro}, 64'd1);
        check("t4_len0_run", {63'd0, core_run}, 64'd0);
        repeat (2) @(negedge clk);
        start(5'd17);
        check("t4_len17_erro", {63'd0, erro}, 64'd1);
        check("t4_len17_palavras", {59'd0, palavras}, 64'd0);
        repeat (3) @(negedge clk);
        check("t4_no_ready", {63'd0, ready_seen}, 64'd0);
        check("t4_no_we", n_we - we_base, 64'd0);

        // 5: full memory with random valid gaps
        we_base = n_we;
        start(5'd16);
        for (int i = 0; i < 16; i++) send_word($urandom, 1, 0);
        check("t5_run_before_check", {63'd0, core_run}, 64'd0);
        send_check(1, 1);
        wait_done();
        check("t5_core_run", {63'd0, core_run}, 64'd1);
        check("t5_palavras", {59'd0, palavras}, 64'd16);
        check("t5_writes", n_we - we_base, 64'd16);
        check("t5_sb_empty", sb.size(), 64'd0);

        // 6a: asynchronous abort mid-word
        start(5'd4);
        send_word(32'hDEADBEEF, 0, 0);
        send_word(32'h12345678, 0, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        byte_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t6_async_reset", {16'd0, byte_ready, mem_we, mem_ender, mem_dado, ocupado, core_run, erro, palavras}, 64'd0);
        check("t6_sb_empty", sb.size(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_idle_ready", {63'd0, byte_ready}, 64'd0);

        // 6b: inicio during RECEBE is ignored
        start(5'd2);
        send_word(32'hCAFEF00D, 0, 0);
        send_word(32'h0BADC0DE, 0, 1);
        send_check(1, 0);
        wait_done();
        check("t6_core_run", {63'd0, core_run}, 64'd1);
        check("t6_erro", {63'd0, erro}, 64'd0);
        check("t6_palavras", {59'd0, palavras}, 64'd2);
        check("t6_sb_empty_end", sb.size(), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
